imem_line_responder: RTL and testbench

- Memory-side responder for the instruction-cache line-fill handshake (irequest/ireqack/iaddr/idata/idone).
- Accepts one 64-byte line request from the instruction cache and issues one read to the memory bus.
- Assembles eight 64-bit response beats into a 512-bit line and returns it with a one-cycle idone pulse.
- Sits between the instruction cache and the memory bus.

---
 rtl/imem_pkg.sv | 27 ++
 rtl/imem_line_assembler.sv | 45 ++++
 rtl/imem_line_responder.sv | 110 +++++++++++
 tb/tb_imem_line_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-cache line-fill responder.
// One line is 64 bytes, returned as eight 64-bit memory beats.
package imem_pkg;

    localparam int LINE_BYTES  = 64;
    localparam int LINE_BITS   = 512;
    localparam int BEAT_BITS   = 64;
    localparam int BEATS       = LINE_BITS / BEAT_BITS;
    localparam int OFFSET_BITS = $clog2(LINE_BYTES);
    localparam int ADDR_BITS   = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        COLLECT = 2'd2,
        DONE    = 2'd3
    } state_e;

    // Clears the byte-offset bits so the bus always sees a line-aligned address.
    function automatic logic [ADDR_BITS-1:0] line_addr(input logic [ADDR_BITS-1:0] addr,
                                                       input int off_bits);
        logic [ADDR_BITS-1:0] mask;
        mask = ~((ADDR_BITS'(1) << off_bits) - ADDR_BITS'(1));
        return addr & mask;
    endfunction

endpackage

// File: rtl/imem_line_assembler.sv
// Beat counter plus line register: each write drops one beat into the next
// slot, lowest address first; o_last flags the beat that completes the line.
module imem_line_assembler
    import imem_pkg::*;
#(
    parameter int LineWidth = LINE_BITS,
    parameter int BeatWidth = BEAT_BITS,
    parameter int Beats     = LineWidth / BeatWidth
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_clear,
    input  logic                 i_write,
    input  logic [BeatWidth-1:0] i_data,
    output logic [LineWidth-1:0] o_line,
    output logic                 o_last
);

    localparam int CntW = $clog2(Beats);

    logic [CntW-1:0]      r_beat_cnt;
    logic [LineWidth-1:0] r_line;

    // NOTE: the line is a plain register, not a RAM, so it takes the reset;
    // the cache must see an all-zero idata after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_beat_cnt <= '0;
            r_line     <= '0;
        end else if (i_clear) begin
            r_beat_cnt <= '0;
        end else if (i_write) begin
            for (int b = 0; b < Beats; b++) begin
                if (r_beat_cnt == CntW'(b)) begin
                    r_line[b*BeatWidth +: BeatWidth] <= i_data;
                end
            end
            r_beat_cnt <= r_beat_cnt + CntW'(1);
        end
    end

    assign o_line = r_line;
    assign o_last = i_write && (r_beat_cnt == CntW'(Beats - 1));

endmodule

// File: rtl/imem_line_responder.sv
// Memory-side responder for instruction-cache line fills: accepts one request,
// issues one aligned bus read, assembles the beats and pulses idone.
module imem_line_responder
    import imem_pkg::*;
#(
    parameter int LineWidth   = LINE_BITS,
    parameter int BeatWidth   = BEAT_BITS,
    parameter int Beats       = BEATS,
    parameter int OffsetWidth = OFFSET_BITS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 irequest,
    output logic                 ireqack,
    input  logic [63:0]          iaddr,
    output logic [LineWidth-1:0] idata,
    output logic                 idone,
    output logic                 mreq_valid,
    input  logic                 mreq_ready,
    output logic [63:0]          mreq_addr,
    input  logic                 mresp_valid,
    input  logic [BeatWidth-1:0] mresp_data,
    output logic                 proto_err
);

    state_e      r_state;
    state_e      w_state_nxt;
    logic        r_ireqack;
    logic        r_idone;
    logic        r_mreq_valid;
    logic        r_proto_err;
    logic [63:0] r_mreq_addr;

    logic w_accept;
    logic w_ireqack_nxt;
    logic w_idone_nxt;
    logic w_mreq_valid_nxt;
    logic w_proto_err_nxt;
    logic w_beat_clear;
    logic w_beat_write;
    logic w_last;

    assign w_accept = (r_state == IDLE) && irequest;

    // NOTE: state and outputs use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_ireqack    <= 1'b0;
            r_idone      <= 1'b0;
            r_mreq_valid <= 1'b0;
            r_proto_err  <= 1'b0;
            r_mreq_addr  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_ireqack    <= w_ireqack_nxt;
            r_idone      <= w_idone_nxt;
            r_mreq_valid <= w_mreq_valid_nxt;
            r_proto_err  <= w_proto_err_nxt;
            if (w_accept) begin
                r_mreq_addr <= line_addr(iaddr, OffsetWidth);
            end
        end
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (irequest)   w_state_nxt = ISSUE;
            ISSUE:   if (mreq_ready) w_state_nxt = COLLECT;
            COLLECT: if (w_last)     w_state_nxt = DONE;
            DONE:                    w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; a response beat outside COLLECT
    // (including the acceptance cycle) is dropped and flagged.
    always_comb begin
        w_ireqack_nxt    = w_accept;
        w_mreq_valid_nxt = w_accept || ((r_state == ISSUE) && !mreq_ready);
        w_idone_nxt      = w_last;
        w_proto_err_nxt  = r_proto_err || (mresp_valid && (r_state != COLLECT));
        w_beat_clear     = (r_state == ISSUE) && mreq_ready;
        w_beat_write     = (r_state == COLLECT) && mresp_valid;
    end

    imem_line_assembler #(
        .LineWidth (LineWidth),
        .BeatWidth (BeatWidth),
        .Beats     (Beats)
    ) u_assembler (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (w_beat_clear),
        .i_write (w_beat_write),
        .i_data  (mresp_data),
        .o_line  (idata),
        .o_last  (w_last)
    );

    assign ireqack    = r_ireqack;
    assign idone      = r_idone;
    assign mreq_valid = r_mreq_valid;
    assign mreq_addr  = r_mreq_addr;
    assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_imem_line_responder.sv
// Self-checking bench for imem_line_responder: directed scenarios plus random
// fills compared against a transaction-level model of the expected line.
module tb_imem_line_responder;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         irequest;
    logic         ireqack;
    logic [63:0]  iaddr;
    logic [511:0] idata;
    logic         idone;
    logic         mreq_valid;
    logic         mreq_ready;
    logic [63:0]  mreq_addr;
    logic         mresp_valid;
    logic [63:0]  mresp_data;
    logic         proto_err;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [511:0] prev_line;
    bit           exp_perr;

    always #5 clk = ~clk;

    imem_line_responder dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .irequest    (irequest),
        .ireqack     (ireqack),
        .iaddr       (iaddr),
        .idata       (idata),
        .idone       (idone),
        .mreq_valid  (mreq_valid),
        .mreq_ready  (mreq_ready),
        .mreq_addr   (mreq_addr),
        .mresp_valid (mresp_valid),
        .mresp_data  (mresp_data),
        .proto_err   (proto_err)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ireqack"},    512'(ireqack),    512'(0));
        check({tag, " idone"},      512'(idone),      512'(0));
        check({tag, " idata"},      idata,            512'(0));
        check({tag, " mreq_valid"}, 512'(mreq_valid), 512'(0));
        check({tag, " mreq_addr"},  512'(mreq_addr),  512'(0));
        check({tag, " proto_err"},  512'(proto_err),  512'(0));
    endtask

    // One complete fill. Expected timing: ack one cycle after the request,
    // one acceptance cycle after ready_delay stalls, then one cycle per beat or gap.
    task automatic do_fill(input logic [63:0] addr, input int ready_delay, input int gap_at,
                           input int gap_len, input bit stray_issue, input bit poke_done,
                           input bit seq_beats);
        logic [63:0]  beats[8];
        logic [511:0] line;
        logic [63:0]  exp_addr;
        int           cyc;
        int           exp_lat;

        for (int k = 0; k < 8; k++) begin
            beats[k] = seq_beats ? 64'(k) : {$urandom, $urandom};
            line[k*64 +: 64] = beats[k];
        end
        exp_addr = {addr[63:6], 6'b0};
        exp_lat  = 2 + ready_delay + 8 + ((gap_at < 8) ? gap_len : 0);
        cyc      = 0;

        irequest = 1'b1;
        iaddr    = addr;
        check("idata held at request", idata, prev_line);
        step(); cyc++;
        check("ireqack", 512'(ireqack), 512'(1));
        check("mreq_valid raised", 512'(mreq_valid), 512'(1));
        check("mreq_addr aligned", 512'(mreq_addr), 512'(exp_addr));
        irequest = 1'b0;
        iaddr    = {$urandom, $urandom};

        for (int d = 0; d < ready_delay; d++) begin
            mreq_ready = 1'b0;
            if (stray_issue && d == 0) begin
                mresp_valid = 1'b1;
                mresp_data  = {$urandom, $urandom};
                exp_perr    = 1'b1;
            end
            step(); cyc++;
            mresp_valid = 1'b0;
            check("mreq_valid stall", 512'(mreq_valid), 512'(1));
            check("mreq_addr stall", 512'(mreq_addr), 512'(exp_addr));
            check("ireqack single pulse", 512'(ireqack), 512'(0));
        end

        mreq_ready = 1'b1;
        if (stray_issue && ready_delay == 0) begin
            mresp_valid = 1'b1;
            mresp_data  = {$urandom, $urandom};
            exp_perr    = 1'b1;
        end
        step(); cyc++;
        mreq_ready  = 1'b0;
        mresp_valid = 1'b0;
        check("mreq_valid dropped", 512'(mreq_valid), 512'(0));
        check("ireqack low after accept", 512'(ireqack), 512'(0));
        check("idata before beats", idata, prev_line);
        check("proto_err after issue", 512'(proto_err), 512'(exp_perr));

        for (int k = 0; k < 8; k++) begin
            if (k == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    irequest = 1'b1;
                    step(); cyc++;
                    check("idone in gap", 512'(idone), 512'(0));
                    check("ireqack ignored in gap", 512'(ireqack), 512'(0));
                end
                irequest = 1'b0;
            end
            mresp_valid = 1'b1;
            mresp_data  = beats[k];
            step(); cyc++;
            mresp_valid = 1'b0;
            if (k < 7) begin
                check("idone early", 512'(idone), 512'(0));
            end else begin
                check("idone", 512'(idone), 512'(1));
                check("idata line", idata, line);
                check("latency", 512'(cyc), 512'(exp_lat));
            end
        end

        if (poke_done) irequest = 1'b1;
        step();
        irequest = 1'b0;
        check("idone single pulse", 512'(idone), 512'(0));
        check("idata held after done", idata, line);
        check("proto_err after fill", 512'(proto_err), 512'(exp_perr));
        check("ireqack after done", 512'(ireqack), 512'(0));
        if (poke_done) begin
            step();
            check("request in DONE ignored", 512'(ireqack), 512'(0));
            check("no issue from DONE request", 512'(mreq_valid), 512'(0));
        end
        prev_line = line;
    endtask

    task automatic stray_beat_idle();
        mresp_valid = 1'b1;
        mresp_data  = {$urandom, $urandom};
        exp_perr    = 1'b1;
        step();
        mresp_valid = 1'b0;
        check("proto_err set in IDLE", 512'(proto_err), 512'(1));
        check("stray beat dropped", idata, prev_line);
        check("no ack from stray", 512'(ireqack), 512'(0));
        step();
        check("proto_err sticky", 512'(proto_err), 512'(1));
    endtask

    task automatic reset_mid_collect();
        irequest = 1'b1;
        iaddr    = 64'h3000;
        step();
        irequest   = 1'b0;
        mreq_ready = 1'b1;
        step();
        mreq_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mresp_valid = 1'b1;
            mresp_data  = {$urandom, $urandom};
            step();
        end
        mresp_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_all_zero("async reset");
        prev_line = '0;
        exp_perr  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("no idone in reset", 512'(idone), 512'(0));
        end
        reset_n = 1'b1;
        step();
        check("idle after reset ireqack", 512'(ireqack), 512'(0));
        check("idle after reset mreq_valid", 512'(mreq_valid), 512'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        irequest    = 1'b0;
        iaddr       = '0;
        mreq_ready  = 1'b0;
        mresp_valid = 1'b0;
        mresp_data  = '0;
        prev_line   = '0;
        exp_perr    = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        reset_n = 1'b1;
        step();

        // Zero-wait fill with beats 0..7.
        do_fill(64'h1000, 0, 8, 0, 1'b0, 1'b0, 1'b1);
        check("beat0 low slot", 512'(idata[63:0]), 512'(0));
        check("beat7 high slot", 512'(idata[511:448]), 512'(7));

        // Misaligned address, then backpressure with a gap before beat 4.
        do_fill(64'h1234, 0, 8, 0, 1'b0, 1'b0, 1'b0);
        do_fill(64'h5678, 5, 4, 2, 1'b0, 1'b0, 1'b0);

        // Back-to-back: the next request is raised in the cycle after idone.
        do_fill(64'h2000, 0, 8, 0, 1'b0, 1'b0, 1'b0);
        do_fill(64'h2040, 1, 0, 3, 1'b0, 1'b1, 1'b0);

        // Stray beat in IDLE; following fill still completes.
        stray_beat_idle();
        do_fill(64'h4000, 2, 8, 0, 1'b0, 1'b0, 1'b0);

        reset_mid_collect();
        do_fill(64'h1000, 0, 8, 0, 1'b0, 1'b0, 1'b1);
        check("clean after reset", 512'(proto_err), 512'(0));

        for (int t = 0; t < 24; t++) begin
            do_fill({$urandom, $urandom}, $urandom_range(0, 5), $urandom_range(0, 8),
                    $urandom_range(1, 3), ($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
